// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control unit and its ALU decoder.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd5;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decode from the FSM's ALU op class and instruction funct fields.
module alu_decoder
  import rv_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic [1:0]            alu_op_i,
  input  logic [2:0]            funct3_i,
  input  logic                  funct7_5_i,
  input  logic                  op_5_i,
  output logic [ALU_CTRL_W-1:0] alu_control_o,
  output logic                  illegal_o
);

  logic [2:0] code;

  // opcode[5] separates R-type from I-type, so addi with imm[10]=1 still adds
  always_comb begin
    code      = ALU_ADD;
    illegal_o = 1'b0;
    case (alu_op_i)
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  code = (funct7_5_i && op_5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  code = ALU_SLT;
          3'b110:  code = ALU_OR;
          3'b111:  code = ALU_AND;
          default: illegal_o = 1'b1;
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

  assign alu_control_o = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_ctrl.sv
// RV32I multicycle control FSM with mem_ready wait states, access timeout and sticky trap.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W  = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  instruction_or_data,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [3:0]            current_state,
  output logic                  illegal_instr,
  output logic                  bus_error
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] TO_MAX   = '1;

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            illegal_q, illegal_d;
  logic            bus_q, bus_d;
  logic [1:0]      alu_op;
  logic            dec_illegal, funct7_ok, timeout_hit;
  logic            mem_write_c, reg_write_c, ir_write_c, pc_write_c;

  alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .funct7_5_i    (funct7[5]),
    .op_5_i        (opcode[5]),
    .alu_control_o (alu_control),
    .illegal_o     (dec_illegal)
  );

  assign funct7_ok   = (funct7 == 7'h00) || (funct7 == 7'h20);
  assign timeout_hit = (MEM_TIMEOUT != 0) && (to_q == TO_LIMIT) && !mem_ready;

  always_comb begin
    mem_req             = 1'b0;
    mem_write_c         = 1'b0;
    reg_write_c         = 1'b0;
    ir_write_c          = 1'b0;
    pc_write_c          = 1'b0;
    instruction_or_data = 1'b0;
    result_src          = RES_ALUOUT;
    alu_src_a           = SRC_A_PC;
    alu_src_b           = SRC_B_RS2;
    imm_src             = IMM_I;
    alu_op              = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALURESULT;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        imm_src   = IMM_B;
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        imm_src   = (opcode == OP_SW) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        mem_req             = 1'b1;
        instruction_or_data = 1'b1;
      end
      S_MEMWB: begin
        result_src  = RES_MEMDATA;
        reg_write_c = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req             = 1'b1;
        mem_write_c         = 1'b1;
        instruction_or_data = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write_c = 1'b1;
      S_JAL: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        imm_src    = IMM_J;
        pc_write_c = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = SRC_A_RS1;
        alu_op     = ALUOP_SUB;
        pc_write_c = zero;
      end
      default: ;
    endcase
  end

  // A completing mem_ready always beats the timeout in the same cycle
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_d     = bus_q;
    case (state_q)
      S_FETCH:
        if (mem_ready) state_d = S_DECODE;
        else if (timeout_hit) begin state_d = S_TRAP; bus_d = 1'b1; end
      S_DECODE:
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin state_d = S_TRAP; illegal_d = 1'b1; end
        endcase
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:
        if (mem_ready) state_d = S_MEMWB;
        else if (timeout_hit) begin state_d = S_TRAP; bus_d = 1'b1; end
      S_MEMWB: state_d = S_FETCH;
      S_MEMWRITE:
        if (mem_ready) state_d = S_FETCH;
        else if (timeout_hit) begin state_d = S_TRAP; bus_d = 1'b1; end
      S_EXECUTER:
        if (dec_illegal || !funct7_ok) begin state_d = S_TRAP; illegal_d = 1'b1; end
        else state_d = S_ALUWB;
      S_EXECUTEI:
        if (dec_illegal) begin state_d = S_TRAP; illegal_d = 1'b1; end
        else state_d = S_ALUWB;
      S_ALUWB: state_d = S_FETCH;
      S_JAL:   state_d = S_ALUWB;
      S_BEQ:   state_d = S_FETCH;
      default: state_d = S_TRAP;
    endcase

    to_d = to_q;
    if ((state_d != state_q) &&
        (state_d == S_FETCH || state_d == S_MEMREAD || state_d == S_MEMWRITE))
      to_d = '0;
    else if (mem_req && !mem_ready && (to_q != TO_MAX))
      to_d = to_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      to_q      <= '0;
      illegal_q <= 1'b0;
      bus_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_q      <= to_d;
      illegal_q <= illegal_d;
      bus_q     <= bus_d;
    end
  end

  assign mem_write     = mem_write_c & reset;
  assign reg_write     = reg_write_c & reset;
  assign ir_write      = ir_write_c & reset;
  assign pc_write      = pc_write_c & reset;
  assign current_state = state_q;
  assign illegal_instr = illegal_q;
  assign bus_error     = bus_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction cycle traces from a reference model,
// compared every cycle by an independent monitor.
module tb_multicycle_ctrl;

  localparam int ALU_CTRL_W  = 3;
  localparam int MEM_TIMEOUT = 15;
  localparam int TO_W        = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic                  zero;
  logic                  mem_ready;
  logic                  mem_req, mem_write, reg_write, ir_write, pc_write;
  logic                  instruction_or_data;
  logic [1:0]            result_src, alu_src_a, alu_src_b, imm_src;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic [3:0]            current_state;
  logic                  illegal_instr, bus_error;

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .ALU_CTRL_W (ALU_CTRL_W),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_W       (TO_W)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .opcode              (opcode),
    .funct3              (funct3),
    .funct7              (funct7),
    .zero                (zero),
    .mem_ready           (mem_ready),
    .mem_req             (mem_req),
    .mem_write           (mem_write),
    .reg_write           (reg_write),
    .ir_write            (ir_write),
    .pc_write            (pc_write),
    .instruction_or_data (instruction_or_data),
    .result_src          (result_src),
    .alu_src_a           (alu_src_a),
    .alu_src_b           (alu_src_b),
    .imm_src             (imm_src),
    .alu_control         (alu_control),
    .current_state       (current_state),
    .illegal_instr       (illegal_instr),
    .bus_error           (bus_error)
  );

  // mask bits select which mux fields a state defines: 5 alu, 4 imm, 3 b, 2 a, 1 res, 0 iord
  typedef struct packed {
    logic [3:0] st;
    logic       req, wr, rw, irw, pcw, ill, be, iord;
    logic [1:0] res, a, b, imm;
    logic [2:0] alu;
    logic [5:0] mask;
  } exp_t;

  exp_t expQ[$];
  exp_t tQ[$];
  bit   rQ[$];
  exp_t monExp, monAct;
  int   errors = 0;
  int   checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t rec(input int st);
    exp_t e;
    e      = '0;
    e.st   = st[3:0];
    return e;
  endfunction

  function automatic logic [31:0] pack(input exp_t e);
    return {9'b0, e.st, e.req, e.wr, e.rw, e.irw, e.pcw, e.ill, e.be,
            e.mask[0] ? e.iord : 1'b0,
            e.mask[1] ? e.res : 2'b0,
            e.mask[2] ? e.a   : 2'b0,
            e.mask[3] ? e.b   : 2'b0,
            e.mask[4] ? e.imm : 2'b0,
            e.mask[5] ? e.alu : 3'b0};
  endfunction

  // Monitor: one expected record per cycle whenever the scoreboard holds one
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monExp      = expQ.pop_front();
      monAct      = rec(int'(current_state));
      monAct.req  = mem_req;
      monAct.wr   = mem_write;
      monAct.rw   = reg_write;
      monAct.irw  = ir_write;
      monAct.pcw  = pc_write;
      monAct.ill  = illegal_instr;
      monAct.be   = bus_error;
      monAct.iord = instruction_or_data;
      monAct.res  = result_src;
      monAct.a    = alu_src_a;
      monAct.b    = alu_src_b;
      monAct.imm  = imm_src;
      monAct.alu  = alu_control;
      monAct.mask = monExp.mask;
      checkOutput($sformatf("cycle in state %0d", monExp.st), pack(monAct), pack(monExp));
    end
  end

  task automatic push(input exp_t e, input bit rdy);
    tQ.push_back(e);
    rQ.push_back(rdy);
  endtask

  task automatic trapCycles(input bit ill, input bit be);
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      e     = rec(11);
      e.ill = ill;
      e.be  = be;
      push(e, 1'($urandom));
    end
  endtask

  // An access sees `waits` not-ready cycles; more than MEM_TIMEOUT of them aborts it
  task automatic memAccess(input exp_t base, input int waits, input bit isFetch, output bit timedOut);
    exp_t e;
    bit   rdy;
    timedOut = 1'b0;
    for (int i = 0; i < 64; i++) begin
      e   = base;
      rdy = (i == waits);
      if (rdy && isFetch) begin
        e.irw = 1'b1;
        e.pcw = 1'b1;
      end
      push(e, rdy);
      if (rdy) break;
      if (i == MEM_TIMEOUT) begin
        timedOut = 1'b1;
        break;
      end
    end
  endtask

  task automatic refAlu(input logic [2:0] f3, input logic [6:0] f7, input bit isR,
                        output logic [2:0] code, output bit bad);
    bad  = isR && !(f7 == 7'h00 || f7 == 7'h20);
    code = 3'd0;
    case (f3)
      3'd0:    code = (isR && f7[5]) ? 3'd1 : 3'd0;
      3'd2:    code = 3'd5;
      3'd6:    code = 3'd3;
      3'd7:    code = 3'd2;
      default: bad = 1'b1;
    endcase
  endtask

  task automatic buildTrace(input logic [31:0] ins, input bit z, input int wf, input int wm);
    logic [6:0] op;
    logic [2:0] code;
    bit         to, bad, isR, wb;
    exp_t       e;
    op = ins[6:0];
    wb = 1'b0;
    tQ.delete();
    rQ.delete();
    e = rec(0); e.req = 1; e.b = 2; e.res = 2; e.mask = 6'b101111;
    memAccess(e, wf, 1'b1, to);
    if (to) begin trapCycles(1'b0, 1'b1); return; end
    e = rec(1); e.a = 1; e.b = 1; e.imm = 2; e.mask = 6'b111100;
    push(e, 1'($urandom));
    case (op)
      7'h03, 7'h23: begin
        e = rec(2); e.a = 2; e.b = 1; e.imm = (op == 7'h23) ? 2'd1 : 2'd0; e.mask = 6'b111100;
        push(e, 1'($urandom));
        if (op == 7'h03) begin
          e = rec(3); e.req = 1; e.iord = 1; e.mask = 6'b000011;
          memAccess(e, wm, 1'b0, to);
          if (to) trapCycles(1'b0, 1'b1);
          else begin
            e = rec(4); e.res = 1; e.rw = 1; e.mask = 6'b000010;
            push(e, 1'($urandom));
          end
        end else begin
          e = rec(5); e.req = 1; e.wr = 1; e.iord = 1; e.mask = 6'b000011;
          memAccess(e, wm, 1'b0, to);
          if (to) trapCycles(1'b0, 1'b1);
        end
      end
      7'h33, 7'h13: begin
        isR = (op == 7'h33);
        refAlu(ins[14:12], ins[31:25], isR, code, bad);
        e = rec(isR ? 6 : 8); e.a = 2; e.b = isR ? 2'd0 : 2'd1; e.alu = code;
        e.mask = isR ? 6'b101100 : 6'b111100;
        if (bad) e.mask[5] = 1'b0;
        push(e, 1'($urandom));
        if (bad) trapCycles(1'b1, 1'b0);
        else wb = 1'b1;
      end
      7'h6F: begin
        e = rec(9); e.a = 1; e.b = 2; e.pcw = 1; e.mask = 6'b101110;
        push(e, 1'($urandom));
        wb = 1'b1;
      end
      7'h63: begin
        e = rec(10); e.a = 2; e.alu = 1; e.pcw = z; e.mask = 6'b101110;
        push(e, 1'($urandom));
      end
      default: trapCycles(1'b1, 1'b0);
    endcase
    if (wb) begin
      e = rec(7); e.rw = 1; e.mask = 6'b000010;
      push(e, 1'($urandom));
    end
  endtask

  task automatic doReset(input string name);
    mem_ready = 1'b1;
    reset     = 1'b0;
    #1;
    checkOutput(name, {24'b0, current_state, illegal_instr, bus_error, mem_write,
                       reg_write, ir_write, pc_write}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input bit z, input int wf, input int wm,
                               input int abortAfter);
    bit trapped;
    buildTrace(ins, z, wf, wm);
    if (abortAfter > 0)
      while (tQ.size() > abortAfter) begin
        void'(tQ.pop_back());
        void'(rQ.pop_back());
      end
    trapped = (tQ[tQ.size()-1].st == 4'd11);
    opcode  = ins[6:0];
    funct3  = ins[14:12];
    funct7  = ins[31:25];
    zero    = z;
    foreach (tQ[i]) expQ.push_back(tQ[i]);
    for (int i = 0; i < tQ.size(); i++) begin
      mem_ready = rQ[i];
      @(posedge clk);
      #1;
    end
    if (abortAfter > 0) doReset("reset during access");
    else if (trapped) doReset("async reset from trap");
  endtask

  logic [2:0]  legalF3 [4] = '{3'd0, 3'd2, 3'd6, 3'd7};
  logic [6:0]  opList  [6] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h6F, 7'h63};

  initial begin
    logic [31:0] ins;
    logic [6:0]  op;
    int          cls, wf, wm;
    reset     = 1'b0;
    mem_ready = 1'b1;
    opcode    = '0;
    funct3    = '0;
    funct7    = '0;
    zero      = 1'b0;
    #2;
    checkOutput("reset state", {24'b0, current_state, illegal_instr, bus_error, mem_write,
                                reg_write, ir_write, pc_write}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset hold with mem_ready", {24'b0, current_state, illegal_instr, bus_error,
                mem_write, reg_write, ir_write, pc_write}, 32'd0);
    reset = 1'b1;

    applyStimulus(32'h00112023, 1'b0, 0, 0, 0);
    applyStimulus(32'h00012083, 1'b0, 0, 3, 0);
    applyStimulus(32'h002081B3, 1'b0, 0, 0, 0);
    applyStimulus(32'h402081B3, 1'b0, 0, 0, 0);
    applyStimulus(32'h00208063, 1'b1, 0, 0, 0);
    applyStimulus(32'h00208063, 1'b0, 0, 0, 0);
    applyStimulus(32'h000000EF, 1'b0, 0, 0, 0);
    applyStimulus(32'h40108093, 1'b0, 2, 0, 0);
    applyStimulus(32'h0000007F, 1'b0, 0, 0, 0);
    applyStimulus(32'h002081B3, 1'b0, 16, 0, 0);
    applyStimulus(32'h002081B3, 1'b0, 15, 0, 0);
    applyStimulus(32'h00012083, 1'b0, 1, 16, 0);
    applyStimulus(32'h00112023, 1'b0, 0, 15, 0);
    applyStimulus(32'h022081B3, 1'b0, 0, 0, 0);
    applyStimulus(32'h002091B3, 1'b0, 0, 0, 0);
    applyStimulus(32'h00112023, 1'b0, 0, 3, 4);

    for (int n = 0; n < 40; n++) begin
      ins = $urandom;
      cls = $urandom_range(0, 6);
      if (cls < 6) op = opList[cls];
      else begin
        op = 7'($urandom);
        while (op == 7'h03 || op == 7'h23 || op == 7'h33 || op == 7'h13 ||
               op == 7'h6F || op == 7'h63)
          op = 7'($urandom);
      end
      ins[6:0] = op;
      if (op == 7'h33) begin
        ins[14:12] = ($urandom_range(0, 4) == 0) ? 3'($urandom) : legalF3[$urandom_range(0, 3)];
        ins[31:25] = ($urandom_range(0, 4) == 0) ? 7'($urandom)
                                                 : ($urandom_range(0, 1) == 1 ? 7'h20 : 7'h00);
      end else if (op == 7'h13) begin
        ins[14:12] = legalF3[$urandom_range(0, 3)];
      end
      wf = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 18) : $urandom_range(0, 3);
      wm = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 18) : $urandom_range(0, 3);
      applyStimulus(ins, 1'($urandom), wf, wm, 0);
    end

    repeat (2) @(posedge clk);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
